// File: rtl/clk_divider_prog_if.sv
// Bundles the run request, divide factor and status outputs of clk_divider_prog.
// The controller side uses the master modport; the divider uses the slave modport.
interface clk_divider_prog_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [WIDTH-1:0] N;
  logic             out;
  logic             tick;
  logic             n_ack;
  logic             cfg_err;
  logic             busy;

  modport master (
    output enable,
    output N,
    input  out,
    input  tick,
    input  n_ack,
    input  cfg_err,
    input  busy
  );

  modport slave (
    input  enable,
    input  N,
    output out,
    output tick,
    output n_ack,
    output cfg_err,
    output busy
  );
endinterface

// File: rtl/clk_divider_prog.sv
// Programmable integer clock divider: out = clk / N, N in 2..2^WIDTH-1.
// N and enable are taken only when idle or at the last cycle of a period,
// so a running period is always completed and out never produces a runt.
// Optional build macro CLKDIV_ODD_DUTY50_EN adds a negedge copy of the
// posedge output so odd divide factors come out at exactly 50% duty.
module clk_divider_prog #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  clk_divider_prog_if.slave     bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] nreg_q, nreg_d;
  logic             out_p, out_p_d;
  logic             tick_q, tick_d;
  logic             n_ack_q, n_ack_d;
  logic             cfg_err_q, cfg_err_d;
  logic             start_ok;
  logic             at_boundary;
  logic [WIDTH-1:0] cnt_inc;

  // N of 0 or 1 is never used as a period; 1 is promoted to the minimum of 2.
  function automatic logic [WIDTH-1:0] clamp_n(input logic [WIDTH-1:0] n);
    return (n < WIDTH'(2)) ? WIDTH'(2) : n;
  endfunction

  assign start_ok    = bus.enable && (bus.N != '0);
  assign at_boundary = (cnt_q == (nreg_q - WIDTH'(1)));
  assign cnt_inc     = cnt_q + WIDTH'(1);

  // Next-state and next-output decode; a new period always starts with out high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nreg_d    = nreg_q;
    out_p_d   = out_p;
    tick_d    = 1'b0;
    n_ack_d   = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        out_p_d = 1'b0;
        cnt_d   = '0;
        if (start_ok) begin
          state_d   = RUN;
          nreg_d    = clamp_n(bus.N);
          out_p_d   = 1'b1;
          tick_d    = 1'b1;
          n_ack_d   = 1'b1;
          cfg_err_d = (bus.N == WIDTH'(1));
        end
      end
      RUN: begin
        if (at_boundary) begin
          cnt_d = '0;
          if (start_ok) begin
            nreg_d    = clamp_n(bus.N);
            out_p_d   = 1'b1;
            tick_d    = 1'b1;
            n_ack_d   = 1'b1;
            cfg_err_d = (bus.N == WIDTH'(1));
          end else begin
            state_d = IDLE;
            out_p_d = 1'b0;
          end
        end else begin
          cnt_d   = cnt_inc;
          out_p_d = (cnt_inc < (nreg_q >> 1));
        end
      end
      default: begin
        state_d = IDLE;
        out_p_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, period register and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      nreg_q    <= '0;
      out_p     <= 1'b0;
      tick_q    <= 1'b0;
      n_ack_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nreg_q    <= nreg_d;
      out_p     <= out_p_d;
      tick_q    <= tick_d;
      n_ack_q   <= n_ack_d;
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef CLKDIV_ODD_DUTY50_EN
  logic out_n;

  // Half-cycle delayed copy of out_p; ORing it stretches the high phase by 0.5 clk.
  always_ff @(negedge clk) begin
    if (!reset_n) begin
      out_n <= 1'b0;
    end else begin
      out_n <= out_p;
    end
  end

  assign bus.out = nreg_q[0] ? (out_p | out_n) : out_p;
`else
  assign bus.out = out_p;
`endif

  assign bus.tick    = tick_q;
  assign bus.n_ack   = n_ack_q;
  assign bus.cfg_err = cfg_err_q;
  assign bus.busy    = (state_q == RUN);

endmodule
